// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage: widths, bubble
// instruction, FSM encodings and stall-vector bit positions.
package if_fetch_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] IF_REQ  = 2'd0;
    localparam logic [1:0] IF_WAIT = 2'd1;
    localparam logic [1:0] IF_DONE = 2'd2;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem request, response buffer,
// wrong-path kill on decode redirect, and the IF/ID pipeline register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            stall,
    input  logic                  branch_flag,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  stallreq_if,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic                  id_valid
);

    logic [1:0]            r_state;
    logic                  r_kill;
    logic [DATA_WIDTH-1:0] r_req_pc;
    logic [DATA_WIDTH-1:0] r_buf_pc;
    logic [DATA_WIDTH-1:0] r_buf_inst;
    logic [DATA_WIDTH-1:0] r_id_pc;
    logic [DATA_WIDTH-1:0] r_id_inst;
    logic                  r_id_valid;

    logic w_load_id;
    logic w_unused;

    assign imem_req    = (r_state == IF_REQ);
    assign imem_addr   = pc_i;
    assign stallreq_if = (r_state != IF_DONE);

    // Only a buffered, non-redirected instruction released by the IF stall bit enters ID.
    assign w_load_id = (r_state == IF_DONE) && !branch_flag && !stall[STALL_IF];

    assign w_unused = ^stall[5:3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IF_REQ;
            r_kill     <= 1'b0;
            r_req_pc   <= '0;
            r_buf_pc   <= '0;
            r_buf_inst <= NOP_INST;
        end else begin
            case (r_state)
                IF_REQ: begin
                    if (imem_req_ready) begin
                        r_req_pc <= pc_i;
                        r_kill   <= branch_flag;
                        r_state  <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_resp_valid) begin
                        if (r_kill || branch_flag) begin
                            r_kill  <= 1'b0;
                            r_state <= IF_REQ;
                        end else begin
                            r_buf_inst <= imem_resp_data;
                            r_buf_pc   <= r_req_pc;
                            r_state    <= IF_DONE;
                        end
                    end else if (branch_flag) begin
                        r_kill <= 1'b1;
                    end
                end
                IF_DONE: begin
                    if (branch_flag || !stall[STALL_IF]) begin
                        r_state <= IF_REQ;
                    end
                end
                default: r_state <= IF_REQ;
            endcase
        end
    end

    // IF/ID register: load, bubble while ID is free, otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_id_pc    <= '0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else if (w_load_id) begin
            r_id_pc    <= r_buf_pc;
            r_id_inst  <= r_buf_inst;
            r_id_valid <= 1'b1;
        end else if (!stall[STALL_ID]) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end
    end

    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

    a_resp_in_wait: assert property (@(posedge CLK) disable iff (RST)
        imem_resp_valid |-> (r_state == IF_WAIT));
    a_branch_no_pc_stall: assert property (@(posedge CLK) disable iff (RST)
        branch_flag |-> !stall[STALL_PC]);
    a_bubble_is_nop: assert property (@(posedge CLK) disable iff (RST)
        !id_valid |-> (id_inst == NOP_INST));

endmodule
